mem_stage: RTL and testbench

Memory stage of the pipelined ARM core, directly downstream of the execute stage. Holds the EX/MEM pipeline register, runs the data-memory request/response handshake with a small FSM, stalls the front of the pipe while a load or store is outstanding, and holds the MEM/WB register plus the writeback result mux. It supplies `ALUResultM` and `ResultW` back to the execute stage's forwarding muxes.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_stage_if.sv | 13 +
 rtl/mem_stage_lane_align.sv | 26 ++
 rtl/mem_stage.sv | 72 +++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: FSM state, pipeline register layouts and bubble constants for the memory stage
package mem_stage_pkg;
  typedef enum logic {IDLE, WAIT_RSP} mem_state_t;
  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic mem_write;
    logic byte_op;
    logic [3:0] rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
  } exmem_t;
  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic [3:0] rd;
    logic [31:0] alu_out;
    logic [31:0] read_data;
  } memwb_t;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;
  function automatic logic is_memop(exmem_t x);
    return x.memto_reg | x.mem_write;
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus between the memory stage and the data memory
interface mem_stage_if #(parameter int AW = 32);
  logic dmem_req;
  logic dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0] dmem_be;
  logic dmem_gnt;
  logic dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, input dmem_gnt, dmem_rvalid, dmem_rdata);
  modport slave (input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/mem_stage_lane_align.sv
// mem_lane_align: byte-lane enables, store replication and load lane select; byte ops only with MEM_STAGE_BYTE_ACCESS_EN
module mem_lane_align (
  input  logic        byte_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_al
);
`ifdef MEM_STAGE_BYTE_ACCESS_EN
  logic [7:0] lane;
  always_comb begin
    lane = rdata[{addr_lo, 3'b000} +: 8];
    be = byte_op ? 4'b0001 << addr_lo : 4'hF;
    wdata_al = byte_op ? {4{wdata[7:0]}} : wdata;
    rdata_al = byte_op ? {24'h0, lane} : rdata;
  end
`else
  logic unused_byte;
  assign unused_byte = ^{byte_op, addr_lo};
  assign be = 4'hF;
  assign wdata_al = wdata;
  assign rdata_al = rdata;
`endif
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, data-memory handshake FSM, load/store stall and MEM/WB writeback mux
module mem_stage import mem_stage_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          FlushM,
  input  logic          RegWriteE,
  input  logic          MemtoRegE,
  input  logic          MemWriteE,
  input  logic          ByteE,
  input  logic [3:0]    RdE,
  input  logic [DW-1:0] ALUResultE,
  input  logic [DW-1:0] WriteDataE,
  output logic          StallM,
  output logic          RegWriteM,
  output logic [3:0]    RdM,
  output logic [DW-1:0] ALUResultM,
  output logic          RegWriteW,
  output logic [3:0]    RdW,
  output logic [DW-1:0] ResultW,
  mem_stage_if.master   dmem
);
  exmem_t e, m;
  memwb_t w;
  mem_state_t state, state_n;
  logic memop, load, store;
  logic [3:0] be_al;
  logic [31:0] wdata_al, rdata_al;
  assign e = {RegWriteE, MemtoRegE, MemWriteE, ByteE, RdE, ALUResultE, WriteDataE};
  mem_lane_align u_align (
    .byte_op(m.byte_op),
    .addr_lo(m.alu_result[1:0]),
    .wdata(m.write_data),
    .rdata(dmem.dmem_rdata),
    .be(be_al),
    .wdata_al(wdata_al),
    .rdata_al(rdata_al)
  );
  always_comb begin
    memop = is_memop(m);
    store = m.mem_write;
    load = m.memto_reg & ~m.mem_write;
    dmem.dmem_req = (state == IDLE) & memop;
    StallM = memop & ~((state == IDLE) & store & dmem.dmem_gnt) & ~((state == WAIT_RSP) & dmem.dmem_rvalid);
    state_n = (state == IDLE) ? ((dmem.dmem_req & load & dmem.dmem_gnt) ? WAIT_RSP : IDLE)
                              : (dmem.dmem_rvalid ? IDLE : WAIT_RSP);
  end
  assign dmem.dmem_we = m.mem_write;
  assign dmem.dmem_addr = AW'(m.alu_result);
  assign dmem.dmem_wdata = wdata_al;
  assign dmem.dmem_be = memop ? be_al : 4'h0;
  assign RegWriteM = m.reg_write;
  assign RdM = m.rd;
  assign ALUResultM = m.alu_result;
  assign RegWriteW = w.reg_write;
  assign RdW = w.rd;
  assign ResultW = w.memto_reg ? w.read_data : w.alu_out;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // stall freezes M and feeds bubbles into W; flush only matters when M advances
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      m <= EXMEM_BUBBLE;
      w <= MEMWB_BUBBLE;
    end else begin
      if (!StallM) m <= FlushM ? EXMEM_BUBBLE : e;
      w <= StallM ? MEMWB_BUBBLE : {m.reg_write, m.memto_reg, m.rd, m.alu_result, rdata_al};
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic against a transaction-level memory-stage model
module tb_mem_stage;
  logic clk = 0;
  logic reset;
  logic FlushM, RegWriteE, MemtoRegE, MemWriteE, ByteE;
  logic [3:0] RdE;
  logic [31:0] ALUResultE, WriteDataE;
  logic StallM, RegWriteM, RegWriteW;
  logic [3:0] RdM, RdW;
  logic [31:0] ALUResultM, ResultW;
  int vecs = 0;
  int errs = 0;

  mem_stage_if #(.AW(32)) dmem();

  mem_stage #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .FlushM(FlushM),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ByteE(ByteE),
    .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .StallM(StallM), .RegWriteM(RegWriteM), .RdM(RdM), .ALUResultM(ALUResultM),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .dmem(dmem)
  );

  always #5 clk = ~clk;

  task drive_e(input logic rw, mr, mw, b, input logic [3:0] rd, input logic [31:0] alu, wd);
    RegWriteE = rw; MemtoRegE = mr; MemWriteE = mw; ByteE = b;
    RdE = rd; ALUResultE = alu; WriteDataE = wd;
  endtask

  task nop_e;
    drive_e(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task mem_in(input logic g, rv, input logic [31:0] rd);
    dmem.dmem_gnt = g; dmem.dmem_rvalid = rv; dmem.dmem_rdata = rd;
  endtask

  task tick;
    @(posedge clk); #1;
  endtask

  task test_reset;
    #3 reset = 0;
    #10;
    vecs++; if ({StallM, RegWriteM, RdM, ALUResultM, RegWriteW, RdW, ResultW} !== '0) begin errs++; $display("FAIL reset_core got %b %b %h %h %b %h %h want all 0", StallM, RegWriteM, RdM, ALUResultM, RegWriteW, RdW, ResultW); end
    vecs++; if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, dmem.dmem_be} !== '0) begin errs++; $display("FAIL reset_dmem got req=%b we=%b addr=%h wdata=%h be=%h want all 0", dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, dmem.dmem_be); end
    @(negedge clk) reset = 1;
  endtask

  task test_alu;
    drive_e(1, 0, 0, 0, 4'd3, 32'h10, 32'h0); mem_in(0, 0, 0);
    tick;
    vecs++; if ({StallM, RegWriteM, RdM, ALUResultM} !== {1'b0, 1'b1, 4'd3, 32'h10}) begin errs++; $display("FAIL alu_m got stall=%b rw=%b rd=%h alu=%h want 0 1 3 10", StallM, RegWriteM, RdM, ALUResultM); end
    nop_e;
    tick;
    vecs++; if ({StallM, RegWriteW, RdW, ResultW} !== {1'b0, 1'b1, 4'd3, 32'h10}) begin errs++; $display("FAIL alu_w got stall=%b rw=%b rd=%h res=%h want 0 1 3 10", StallM, RegWriteW, RdW, ResultW); end
  endtask

  task test_store;
    drive_e(0, 0, 1, 0, 4'd0, 32'h100, 32'hDEADBEEF); mem_in(0, 0, 0);
    tick;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick;
      nop_e; mem_in(c == 2, 0, 0);
      #1;
      vecs++; if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin errs++; $display("FAIL store_req c%0d got req=%b we=%b addr=%h wdata=%h want 1 1 100 deadbeef", c, dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata); end
      vecs++; if (StallM !== (c != 2)) begin errs++; $display("FAIL store_stall c%0d got %b want %b", c, StallM, c != 2); end
    end
    tick; mem_in(0, 0, 0); #1;
    vecs++; if ({RegWriteW, dmem.dmem_req} !== 2'b00) begin errs++; $display("FAIL store_done got rww=%b req=%b want 0 0", RegWriteW, dmem.dmem_req); end
  endtask

  task test_load;
    drive_e(1, 1, 0, 0, 4'd5, 32'h200, 32'h0); mem_in(0, 0, 0);
    tick;
    nop_e; mem_in(1, 0, 0); #1;
    vecs++; if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, StallM} !== {1'b1, 1'b0, 32'h200, 1'b1}) begin errs++; $display("FAIL load_gnt got req=%b we=%b addr=%h stall=%b want 1 0 200 1", dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, StallM); end
    for (int c = 1; c < 3; c++) begin
      tick; mem_in(0, 0, 0); #1;
      vecs++; if ({dmem.dmem_req, StallM, RegWriteW} !== 3'b010) begin errs++; $display("FAIL load_wait c%0d got req=%b stall=%b rww=%b want 0 1 0", c, dmem.dmem_req, StallM, RegWriteW); end
    end
    tick; mem_in(0, 1, 32'h12345678); #1;
    vecs++; if (StallM !== 1'b0) begin errs++; $display("FAIL load_rsp_stall got %b want 0", StallM); end
    tick; mem_in(0, 0, 0); #1;
    vecs++; if ({RegWriteW, RdW, ResultW} !== {1'b1, 4'd5, 32'h12345678}) begin errs++; $display("FAIL load_w got rw=%b rd=%h res=%h want 1 5 12345678", RegWriteW, RdW, ResultW); end
  endtask

  task test_flush;
    drive_e(1, 0, 0, 0, 4'd7, 32'h77, 32'h0); FlushM = 1; mem_in(0, 0, 0);
    tick;
    FlushM = 0; nop_e;
    vecs++; if ({RegWriteM, RdM, ALUResultM} !== '0) begin errs++; $display("FAIL flush_m got rw=%b rd=%h alu=%h want bubble", RegWriteM, RdM, ALUResultM); end
    tick;
    vecs++; if (RegWriteW !== 1'b0) begin errs++; $display("FAIL flush_w got rww=%b want 0", RegWriteW); end
    drive_e(1, 1, 0, 0, 4'd9, 32'h300, 32'h0);
    tick;
    nop_e; FlushM = 1; mem_in(1, 0, 0); #1;
    vecs++; if (StallM !== 1'b1) begin errs++; $display("FAIL flush_ld_stall got %b want 1", StallM); end
    tick; mem_in(0, 1, 32'hCAFEF00D); #1;
    vecs++; if (StallM !== 1'b0) begin errs++; $display("FAIL flush_ld_rsp got %b want 0", StallM); end
    tick; mem_in(0, 0, 0); FlushM = 0; #1;
    vecs++; if ({RegWriteW, RdW, ResultW} !== {1'b1, 4'd9, 32'hCAFEF00D}) begin errs++; $display("FAIL flush_ld_w got rw=%b rd=%h res=%h want 1 9 cafef00d", RegWriteW, RdW, ResultW); end
  endtask

  task test_reset_wait;
    drive_e(1, 1, 0, 0, 4'd4, 32'h400, 32'h0); mem_in(0, 0, 0);
    tick;
    nop_e; mem_in(1, 0, 0);
    tick; mem_in(0, 0, 0); #1;
    vecs++; if ({dmem.dmem_req, StallM} !== 2'b01) begin errs++; $display("FAIL rstw_wait got req=%b stall=%b want 0 1", dmem.dmem_req, StallM); end
    reset = 0; #2;
    vecs++; if ({dmem.dmem_req, StallM, RegWriteM, RegWriteW} !== 4'b0000) begin errs++; $display("FAIL rstw_in_reset got req=%b stall=%b rwm=%b rww=%b want 0", dmem.dmem_req, StallM, RegWriteM, RegWriteW); end
    @(negedge clk) reset = 1;
    tick; mem_in(0, 1, 32'hBAD0BAD0); #1;
    vecs++; if ({dmem.dmem_req, StallM} !== 2'b00) begin errs++; $display("FAIL rstw_late_rvalid got req=%b stall=%b want 0 0", dmem.dmem_req, StallM); end
    tick; mem_in(0, 0, 0); #1;
    vecs++; if ({RegWriteW, ResultW} !== {1'b0, 32'h0}) begin errs++; $display("FAIL rstw_no_wb got rww=%b res=%h want 0 0", RegWriteW, ResultW); end
  endtask

`ifdef MEM_STAGE_BYTE_ACCESS_EN
  task test_byte;
    drive_e(1, 1, 0, 1, 4'd2, 32'h203, 32'h0); mem_in(0, 0, 0);
    tick;
    nop_e; mem_in(1, 0, 0); #1;
    vecs++; if (dmem.dmem_be !== 4'b1000) begin errs++; $display("FAIL ldrb_be got %b want 1000", dmem.dmem_be); end
    tick; mem_in(0, 1, 32'hAB000000); #1;
    tick; mem_in(0, 0, 0); #1;
    vecs++; if ({RegWriteW, ResultW} !== {1'b1, 32'h000000AB}) begin errs++; $display("FAIL ldrb_w got rw=%b res=%h want 1 000000ab", RegWriteW, ResultW); end
    drive_e(0, 0, 1, 1, 4'd0, 32'h201, 32'h1234565A);
    tick;
    nop_e; mem_in(1, 0, 0); #1;
    vecs++; if ({dmem.dmem_be, dmem.dmem_wdata, StallM} !== {4'b0010, 32'h5A5A5A5A, 1'b0}) begin errs++; $display("FAIL strb got be=%b wdata=%h stall=%b want 0010 5a5a5a5a 0", dmem.dmem_be, dmem.dmem_wdata, StallM); end
    tick; mem_in(0, 0, 0);
  endtask
`endif

  task automatic gen(output logic rw, ld, st, b, output logic [3:0] rd, output logic [31:0] alu, wd);
    int k;
    k = $urandom_range(0, 3);
    ld = (k == 1);
    st = (k == 2);
    rw = (k == 0) | ld;
`ifdef MEM_STAGE_BYTE_ACCESS_EN
    b = 1'b0;
`else
    b = 1'($urandom);
`endif
    rd = 4'($urandom);
    wd = $urandom;
    alu = (ld | st) ? {24'h1, 6'($urandom), 2'b00} : $urandom;
  endtask

  // Model: M holds the last accepted instruction until it completes by the handshake rules; W shows what completed last cycle
  task automatic test_random;
    logic [31:0] mem [64];
    logic m_rw, m_ld, m_st, m_gr, c_rw, c_ld, c_st, c_b, x_rw, fl, g, rv, done, exp_req;
    logic [3:0] m_rd, c_rd, x_rd;
    logic [31:0] m_alu, m_wd, c_alu, c_wd, x_val, rd_v;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    nop_e; FlushM = 0; mem_in(0, 0, 0);
    reset = 0; #2;
    @(negedge clk) reset = 1;
    {m_rw, m_ld, m_st, m_rd, m_alu, m_wd} = 71'h0;
    m_gr = 0; x_rw = 0; x_rd = 0; x_val = 0;
    gen(c_rw, c_ld, c_st, c_b, c_rd, c_alu, c_wd);
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick;
      vecs++; if (RegWriteW !== x_rw) begin errs++; $display("FAIL rnd_rww cyc%0d got %b want %b", cyc, RegWriteW, x_rw); end
      if (x_rw) begin
        vecs++; if ({RdW, ResultW} !== {x_rd, x_val}) begin errs++; $display("FAIL rnd_wb cyc%0d got rd=%h res=%h want rd=%h res=%h", cyc, RdW, ResultW, x_rd, x_val); end
      end
      vecs++; if ({RegWriteM, RdM, ALUResultM} !== {m_rw, m_rd, m_alu}) begin errs++; $display("FAIL rnd_fwd cyc%0d got %b %h %h want %b %h %h", cyc, RegWriteM, RdM, ALUResultM, m_rw, m_rd, m_alu); end
      fl = ($urandom_range(0, 9) == 0);
      drive_e(c_rw, c_ld, c_st, c_b, c_rd, c_alu, c_wd); FlushM = fl;
      exp_req = (m_ld | m_st) & ~m_gr;
      vecs++; if (dmem.dmem_req !== exp_req) begin errs++; $display("FAIL rnd_req cyc%0d got %b want %b", cyc, dmem.dmem_req, exp_req); end
      if (exp_req) begin
        vecs++; if ({dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, dmem.dmem_be} !== {m_st, m_alu, m_wd, 4'hF}) begin errs++; $display("FAIL rnd_payload cyc%0d got we=%b addr=%h wd=%h be=%h want %b %h %h f", cyc, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, dmem.dmem_be, m_st, m_alu, m_wd); end
      end
      g = 1'($urandom);
      rv = ($urandom_range(0, 2) == 0);
      rd_v = m_gr ? mem[m_alu[7:2]] : $urandom;
      mem_in(g, rv, rd_v);
      #1;
      done = ~(m_ld | m_st) | (m_st & g) | (m_ld & m_gr & rv);
      vecs++; if (StallM !== ~done) begin errs++; $display("FAIL rnd_stall cyc%0d got %b want %b", cyc, StallM, ~done); end
      if (done) begin
        x_rw = m_rw; x_rd = m_rd; x_val = m_ld ? rd_v : m_alu;
        if (m_st) mem[m_alu[7:2]] = m_wd;
        {m_rw, m_ld, m_st, m_rd, m_alu, m_wd} = fl ? 71'h0 : {c_rw, c_ld, c_st, c_rd, c_alu, c_wd};
        m_gr = 0;
        gen(c_rw, c_ld, c_st, c_b, c_rd, c_alu, c_wd);
      end else begin
        x_rw = 0;
        if (m_ld & ~m_gr & g) m_gr = 1;
      end
    end
  endtask

  initial begin
    reset = 1; FlushM = 0; nop_e; mem_in(0, 0, 0);
    test_reset;
    test_alu;
    test_store;
    test_load;
    test_flush;
    test_reset_wait;
`ifdef MEM_STAGE_BYTE_ACCESS_EN
    test_byte;
`endif
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
